// File: rtl/block_dispatch.sv
// ETC2 block dispatcher: accepts a compressed block, asks the mode detector for its
// mode, then issues a one-cycle start pulse to the matching decoder with a sequence tag.
module block_dispatch #(
    parameter int MAX_OUT = 4,
    parameter int TMO_CYC = 16
) (
    input  logic        sclk,
    input  logic        rsrt_n,
    input  logic [63:0] blk_in,
    input  logic        blk_flags,
    input  logic        blk_valid,
    output logic        blk_ready,
    output logic [63:0] md_block,
    output logic        md_flags,
    output logic        md_rtr,
    input  logic [2:0]  md_mode,
    input  logic        md_rts,
    output logic [4:0]  dec_req,
    output logic [63:0] dec_block,
    output logic        dec_flags,
    output logic [7:0]  dec_tag,
    input  logic [4:0]  dec_busy,
    input  logic [4:0]  dec_done,
    output logic [2:0]  outstanding,
    output logic        err_mode,
    output logic        err_tmo
);

    localparam int TW = $clog2(TMO_CYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        DETECT,
        DISPATCH
    } state_t;

    state_t        state, state_nx;
    logic [63:0]   hold_blk;
    logic          hold_flg;
    logic [2:0]    mode_q;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    tag_q;
    logic [2:0]    out_q;
    logic [2:0]    out_nx;
    logic          err_mode_q, err_tmo_q;
    logic          accept, dispatch, latch_mode, tmo_hit, drop_bad;
    int            out_sum;

    always_comb begin
        state_nx   = state;
        blk_ready  = 1'b0;
        md_rtr     = 1'b0;
        dec_req    = '0;
        accept     = 1'b0;
        dispatch   = 1'b0;
        latch_mode = 1'b0;
        tmo_hit    = 1'b0;
        drop_bad   = 1'b0;
        case (state)
            IDLE: begin
                blk_ready = 1'b1;
                if (blk_valid) begin
                    accept   = 1'b1;
                    state_nx = DETECT;
                end
            end
            DETECT: begin
                md_rtr = 1'b1;
                if (md_rts) begin
                    latch_mode = 1'b1;
                    state_nx   = DISPATCH;
                end else if (tmo_cnt == TW'(TMO_CYC - 1)) begin
                    tmo_hit  = 1'b1;
                    state_nx = IDLE;
                end
            end
            DISPATCH: begin
                if (mode_q > 3'd4) begin
                    drop_bad = 1'b1;
                    state_nx = IDLE;
                end else if (!dec_busy[mode_q] && int'(out_q) != MAX_OUT) begin
                    dispatch = 1'b1;
                    dec_req  = 5'b00001 << mode_q;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Surplus done pulses saturate at zero rather than wrapping the count.
    always_comb begin
        out_sum = int'(out_q) + (dispatch ? 1 : 0) - $countones(dec_done);
        if (out_sum < 0)
            out_nx = '0;
        else if (out_sum > MAX_OUT)
            out_nx = 3'(MAX_OUT);
        else
            out_nx = 3'(out_sum);
    end

    always_ff @(posedge sclk or negedge rsrt_n) begin
        if (!rsrt_n) begin
            state      <= IDLE;
            hold_blk   <= '0;
            hold_flg   <= 1'b0;
            mode_q     <= '0;
            tmo_cnt    <= '0;
            tag_q      <= '0;
            out_q      <= '0;
            err_mode_q <= 1'b0;
            err_tmo_q  <= 1'b0;
        end else begin
            state <= state_nx;
            out_q <= out_nx;
            if (accept) begin
                hold_blk <= blk_in;
                hold_flg <= blk_flags;
            end
            if (latch_mode)
                mode_q <= md_mode;
            if (state == DETECT && !md_rts && !tmo_hit)
                tmo_cnt <= tmo_cnt + 1'b1;
            else
                tmo_cnt <= '0;
            if (dispatch)
                tag_q <= tag_q + 8'd1;
            if (drop_bad)
                err_mode_q <= 1'b1;
            if (tmo_hit)
                err_tmo_q <= 1'b1;
        end
    end

    assign md_block    = hold_blk;
    assign md_flags    = hold_flg;
    assign dec_block   = hold_blk;
    assign dec_flags   = hold_flg;
    assign dec_tag     = tag_q;
    assign outstanding = out_q;
    assign err_mode    = err_mode_q;
    assign err_tmo     = err_tmo_q;

endmodule

// File: tb/tb_block_dispatch.sv
// Directed-vector bench for block_dispatch: latency, busy/outstanding back-pressure,
// timeout, illegal mode and asynchronous reset abandonment.
module tb_block_dispatch;

    logic        sclk = 1'b0;
    logic        rsrt_n = 1'b0;
    logic [63:0] blk_in = '0;
    logic        blk_flags = 1'b0;
    logic        blk_valid = 1'b0;
    logic        blk_ready;
    logic [63:0] md_block;
    logic        md_flags;
    logic        md_rtr;
    logic [2:0]  md_mode = '0;
    logic        md_rts = 1'b0;
    logic [4:0]  dec_req;
    logic [63:0] dec_block;
    logic        dec_flags;
    logic [7:0]  dec_tag;
    logic [4:0]  dec_busy = '0;
    logic [4:0]  dec_done = '0;
    logic [2:0]  outstanding;
    logic        err_mode;
    logic        err_tmo;

    int n_checks = 0;
    int n_errors = 0;

    block_dispatch #(.MAX_OUT(4), .TMO_CYC(16)) dut (
        .sclk(sclk), .rsrt_n(rsrt_n),
        .blk_in(blk_in), .blk_flags(blk_flags), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .md_block(md_block), .md_flags(md_flags), .md_rtr(md_rtr),
        .md_mode(md_mode), .md_rts(md_rts),
        .dec_req(dec_req), .dec_block(dec_block), .dec_flags(dec_flags), .dec_tag(dec_tag),
        .dec_busy(dec_busy), .dec_done(dec_done), .outstanding(outstanding),
        .err_mode(err_mode), .err_tmo(err_tmo)
    );

    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    // Leaves the bench in the first DISPATCH cycle (cycle 3), just after the edge.
    task automatic do_block(input logic [63:0] b, input logic f, input logic [2:0] m);
        blk_in = b; blk_flags = f; blk_valid = 1'b1;
        #1 check("ready_idle", 64'(blk_ready), 64'd1);
        step();
        blk_valid = 1'b0; md_rts = 1'b0;
        #1 check("md_rtr_c1", 64'(md_rtr), 64'd1);
        check("md_block", md_block, b);
        check("md_flags", 64'(md_flags), 64'(f));
        check("ready_busy", 64'(blk_ready), 64'd0);
        step();
        md_rts = 1'b1; md_mode = m;
        #1 check("md_rtr_c2", 64'(md_rtr), 64'd1);
        check("no_req_c2", 64'(dec_req), 64'd0);
        step();
        md_rts = 1'b0;
        #1;
    endtask

    task automatic reset_checks(input string pfx);
        check({pfx, "_ready"}, 64'(blk_ready), 64'd1);
        check({pfx, "_rtr"}, 64'(md_rtr), 64'd0);
        check({pfx, "_req"}, 64'(dec_req), 64'd0);
        check({pfx, "_tag"}, 64'(dec_tag), 64'd0);
        check({pfx, "_out"}, 64'(outstanding), 64'd0);
        check({pfx, "_errm"}, 64'(err_mode), 64'd0);
        check({pfx, "_errt"}, 64'(err_tmo), 64'd0);
        check({pfx, "_hold"}, md_block, 64'd0);
    endtask

    initial begin
        #12 reset_checks("rst");
        @(posedge sclk); #1 rsrt_n = 1'b1;

        // Minimum-latency dispatch, mode 2
        do_block(64'h0123_4567_89AB_CDEF, 1'b1, 3'd2);
        check("a_req", 64'(dec_req), 64'h04);
        check("a_tag", 64'(dec_tag), 64'd0);
        check("a_blk", dec_block, 64'h0123_4567_89AB_CDEF);
        check("a_flg", 64'(dec_flags), 64'd1);
        step();
        check("a_ready_c4", 64'(blk_ready), 64'd1);
        check("a_req_c4", 64'(dec_req), 64'd0);
        check("a_out", 64'(outstanding), 64'd1);
        dec_done = 5'b00100;
        step();
        dec_done = '0;
        #1 check("a_out_done", 64'(outstanding), 64'd0);

        // Busy decoder stalls dispatch
        dec_busy = 5'b00001;
        do_block(64'hB0B0_0000_0000_0001, 1'b0, 3'd0);
        for (int i = 0; i < 5; i++) begin
            check("b_wait", 64'(dec_req), 64'd0);
            step();
        end
        dec_busy = '0;
        #1 check("b_req", 64'(dec_req), 64'h01);
        check("b_tag", 64'(dec_tag), 64'd1);
        check("b_out0", 64'(outstanding), 64'd0);
        step();
        check("b_out1", 64'(outstanding), 64'd1);
        dec_done = 5'b00001;
        step();
        dec_done = '0;
        #1 check("b_out_done", 64'(outstanding), 64'd0);

        // Fill to MAX_OUT, fifth waits until a done frees a slot
        for (int i = 0; i < 4; i++) begin
            do_block(64'(i + 16), 1'b0, 3'd1);
            check("c_req", 64'(dec_req), 64'h02);
            check("c_tag", 64'(dec_tag), 64'(i + 2));
            step();
        end
        check("c_out4", 64'(outstanding), 64'd4);
        do_block(64'hC5C5, 1'b1, 3'd3);
        for (int i = 0; i < 3; i++) begin
            check("c_full_wait", 64'(dec_req), 64'd0);
            check("c_full_out", 64'(outstanding), 64'd4);
            step();
        end
        dec_done = 5'b00010;
        #1 check("c_req_t", 64'(dec_req), 64'd0);
        step();
        dec_done = '0;
        #1 check("c_req_t1", 64'(dec_req), 64'h08);
        check("c_tag5", 64'(dec_tag), 64'd6);
        check("c_out3", 64'(outstanding), 64'd3);
        step();
        check("c_out_stay4", 64'(outstanding), 64'd4);
        check("c_req_after", 64'(dec_req), 64'd0);
        dec_done = 5'b11111;
        step();
        dec_done = '0;
        #1 check("c_out_clamp", 64'(outstanding), 64'd0);

        // Fresh start, then mode-detect timeout
        rsrt_n = 1'b0;
        #1 check("d_rst_tag", 64'(dec_tag), 64'd0);
        @(posedge sclk); #1 rsrt_n = 1'b1;
        blk_in = 64'hDEAD; blk_valid = 1'b1;
        step();
        blk_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("d_rtr", 64'(md_rtr), 64'd1);
            check("d_noreq", 64'(dec_req), 64'd0);
            step();
        end
        check("d_rtr_off", 64'(md_rtr), 64'd0);
        check("d_idle", 64'(blk_ready), 64'd1);
        check("d_errt", 64'(err_tmo), 64'd1);
        do_block(64'hD2, 1'b0, 3'd0);
        check("d_req", 64'(dec_req), 64'h01);
        check("d_tag", 64'(dec_tag), 64'd0);
        step();

        // Illegal mode dropped, next legal block proceeds
        do_block(64'hE6, 1'b1, 3'd6);
        check("e_noreq", 64'(dec_req), 64'd0);
        step();
        check("e_errm", 64'(err_mode), 64'd1);
        check("e_errt_sticky", 64'(err_tmo), 64'd1);
        check("e_idle", 64'(blk_ready), 64'd1);
        check("e_out", 64'(outstanding), 64'd1);
        do_block(64'hE4, 1'b0, 3'd4);
        check("e_req4", 64'(dec_req), 64'h10);
        check("e_tag", 64'(dec_tag), 64'd1);
        step();

        // Asynchronous reset while stalled in DISPATCH
        dec_busy = 5'b00100;
        do_block(64'hF00D, 1'b1, 3'd2);
        check("f_wait", 64'(dec_req), 64'd0);
        #1 rsrt_n = 1'b0;
        #1 reset_checks("f_async");
        @(posedge sclk); #1 rsrt_n = 1'b1;
        dec_busy = '0;
        for (int i = 0; i < 4; i++) begin
            check("f_noreq", 64'(dec_req), 64'd0);
            check("f_idle", 64'(blk_ready), 64'd1);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/block_dispatch.md
BLOCK_DISPATCH -- requirements
Module: block_dispatch

Interface
REQ-001 SHALL provide parameter MAX_OUT, default 4, meaning the maximum number of dispatched blocks not yet reported done by a decoder.
REQ-002 SHALL provide parameter TMO_CYC, default 16, meaning the DETECT-state cycle limit before a mode-detect timeout.
REQ-003 SHALL have port sclk input 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rsrt_n input 1, asynchronous active-low reset.
REQ-005 SHALL have port blk_in input 64, compressed ETC2 block from the upstream block FIFO.
REQ-006 SHALL have port blk_flags input 1, punch-through flag accompanying blk_in.
REQ-007 SHALL have port blk_valid input 1, upstream block valid.
REQ-008 SHALL have port blk_ready output 1, block accepted when blk_valid and blk_ready are both high.
REQ-009 SHALL have port md_block output 64, the held block driven to the mode detector.
REQ-010 SHALL have port md_flags output 1, the held punch-through flag to the mode detector.
REQ-011 SHALL have port md_rtr output 1, mode-detect request.
REQ-012 SHALL have port md_mode input 3, detected mode; encodings are Individual=0, Differential=1, TMode=2, HMode=3, Planar=4.
REQ-013 SHALL have port md_rts input 1, mode-detect result valid, qualified by md_rtr.
REQ-014 SHALL have port dec_req output 5, one-hot decoder start pulse; bit index equals the mode encoding.
REQ-015 SHALL have port dec_block output 64, block presented to the decoders, valid while dec_req is nonzero.
REQ-016 SHALL have port dec_flags output 1, punch-through flag presented with dec_block.
REQ-017 SHALL have port dec_tag output 8, sequence tag presented with dec_block.
REQ-018 SHALL have port dec_busy input 5, per-decoder busy indication.
REQ-019 SHALL have port dec_done input 5, per-decoder one-cycle completion pulses.
REQ-020 SHALL have port outstanding output 3, count of dispatched blocks not yet done.
REQ-021 SHALL have port err_mode output 1, sticky flag for an illegal mode.
REQ-022 SHALL have port err_tmo output 1, sticky flag for a mode-detect timeout.

Function
REQ-023 SHALL implement the FSM states IDLE, DETECT and DISPATCH.
REQ-024 SHALL drive blk_ready high only in IDLE; on accept, it SHALL register blk_in and blk_flags into a hold register and enter DETECT.
REQ-025 SHALL drive md_block and md_flags from the hold register at all times, stable from accept until the return to IDLE.
REQ-026 In DETECT, SHALL hold md_rtr high until md_rts is sampled high, then latch md_mode and enter DISPATCH; md_rtr SHALL be low in all other states.
REQ-027 In DETECT, SHALL count cycles; if TMO_CYC cycles elapse with no md_rts, it SHALL set err_tmo, drop the block and return to IDLE.
REQ-028 In DISPATCH with a latched mode greater than 4, SHALL set err_mode, drop the block without a dec_req pulse, and return to IDLE.
REQ-029 In DISPATCH with a legal mode m, SHALL wait while dec_busy[m]=1 or outstanding=MAX_OUT.
REQ-030 Once neither DISPATCH wait condition holds, SHALL pulse dec_req[m] for exactly one cycle with dec_block, dec_flags and dec_tag valid in that cycle, then return to IDLE.
REQ-031 SHALL keep dec_req at zero in all cycles other than the dispatch cycle.
REQ-032 SHALL increment dec_tag by 1 modulo 256 after each dispatch; dropped blocks SHALL NOT consume a tag.
REQ-033 SHALL update outstanding each cycle as outstanding + (1 on a dispatch) - popcount(dec_done).
REQ-034 outstanding SHALL never wrap below 0 or exceed MAX_OUT; excess dec_done bits SHALL be ignored.
REQ-035 A simultaneous dispatch and dec_done at outstanding=MAX_OUT SHALL be impossible by REQ-029.
REQ-036 A simultaneous dispatch and dec_done in the same cycle SHALL net to +1-n.
REQ-037 Minimum latency: accept in cycle 0; md_rtr high in cycle 1; md_rts in cycle 2 from a 1-cycle detector; dec_req in cycle 3; blk_ready high again in cycle 4.
REQ-038 Minimum throughput SHALL be one block per 4 cycles.
REQ-039 err_mode and err_tmo SHALL remain set until reset.

Reset
REQ-040 While rsrt_n is low, regardless of sclk: FSM=IDLE; blk_ready=1; md_rtr=0; dec_req=0; dec_tag=0; outstanding=0; err_mode=0; err_tmo=0; hold register=0; timeout counter=0.
REQ-041 Reset asserted mid-operation SHALL abandon the in-flight block with no dec_req pulse.
REQ-042 After rsrt_n deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-043 Accept a block with detector returning mode 2 one cycle after md_rtr, all decoders idle -> dec_req=5'b00100 exactly in cycle 3, dec_tag=0, blk_ready high in cycle 4.
REQ-044 Mode 0 with dec_busy[0] held high for 5 cycles -> dec_req stays 0 for those 5 cycles, then dec_req=5'b00001 once; outstanding goes 0->1.
REQ-045 Dispatch 4 blocks with no dec_done, then offer a fifth -> fifth waits in DISPATCH; a dec_done pulse in cycle t -> dec_req in cycle t+1 and outstanding stays 4.
REQ-046 md_rts never asserted -> after 16 DETECT cycles err_tmo=1, FSM=IDLE, no dec_req pulse, next block still dispatches with dec_tag=0.
REQ-047 md_mode=6 -> err_mode=1, no dec_req pulse; a following mode-4 block gets dec_req=5'b10000.
REQ-048 rsrt_n pulsed low while in DISPATCH waiting on busy -> all outputs return to reset values asynchronously, and no dec_req pulse is emitted afterward for the abandoned block.
